irrigation_controller: RTL and testbench

//   Sequencer/arbiter for the shared irrigation pump and three outlets (sprinkler, drip, specific).

---
 rtl/irrigation_controller.sv | 198 +++++++++++++++++++
 tb/tb_irrigation_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_controller.sv
// Round-robin sequencer for a shared irrigation pump and three outlets: prime, water, rest, tank fault.
// Optional macro IRRIGATION_STATS_EN adds a saturating 16-bit count of valve-open cycles (water_cycles).
module irrigation_controller #(
    parameter int unsigned PRIME_CYCLES = 4,
    parameter int unsigned WATER_CYCLES = 16,
    parameter int unsigned REST_CYCLES  = 8,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sprinkler_req,
    input  logic       drip_req,
    input  logic       specific_req,
    input  logic       soil_umidity,
    input  logic [1:0] water_box,
    output logic       pump_on,
    output logic       sprinkler_valve,
    output logic       drip_valve,
    output logic       specific_valve,
    output logic       busy,
    output logic       tank_fault
`ifdef IRRIGATION_STATS_EN
    ,
    output logic [15:0] water_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_WATER = 3'd2,
        ST_REST  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    // Channel vectors: bit0 sprinkler, bit1 drip, bit2 specific
    logic [2:0]       r_grant, w_grant_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [2:0]       w_req;
    logic [2:0]       w_winner;
    logic [2:0]       w_ptr_adv;
    logic             w_tank_empty;
    logic             w_granted_req;

    logic             r_pump, r_sprinkler, r_drip, r_specific, r_busy, r_fault;
    logic             w_pump_nxt, w_busy_nxt, w_fault_nxt;
    logic [2:0]       w_valve_nxt;

    assign w_req         = {specific_req, drip_req, sprinkler_req};
    assign w_tank_empty  = (water_box == 2'b00);
    assign w_granted_req = |(r_grant & w_req);
    assign w_ptr_adv     = (|r_grant) ? {r_grant[1:0], r_grant[2]} : r_ptr;

    // First requester scanning from the round-robin pointer
    always_comb begin
        w_winner = 3'b000;
        case (r_ptr)
            3'b010: begin
                if (w_req[1])      w_winner = 3'b010;
                else if (w_req[2]) w_winner = 3'b100;
                else if (w_req[0]) w_winner = 3'b001;
            end
            3'b100: begin
                if (w_req[2])      w_winner = 3'b100;
                else if (w_req[0]) w_winner = 3'b001;
                else if (w_req[1]) w_winner = 3'b010;
            end
            default: begin
                if (w_req[0])      w_winner = 3'b001;
                else if (w_req[1]) w_winner = 3'b010;
                else if (w_req[2]) w_winner = 3'b100;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_tank_empty) begin
                    w_state_nxt = ST_FAULT;
                end else if (|w_req) begin
                    w_state_nxt = ST_PRIME;
                    w_grant_nxt = w_winner;
                end
            end
            ST_PRIME: begin
                if (w_tank_empty) begin
                    w_state_nxt = ST_FAULT;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = w_ptr_adv;
                end else if (r_cnt == CNT_W'(PRIME_CYCLES - 1)) begin
                    w_state_nxt = ST_WATER;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WATER: begin
                if (w_tank_empty) begin
                    w_state_nxt = ST_FAULT;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = w_ptr_adv;
                end else if (!w_granted_req || soil_umidity ||
                             (r_cnt == CNT_W'(WATER_CYCLES - 1))) begin
                    w_state_nxt = ST_REST;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = 3'b000;
                    w_ptr_nxt   = w_ptr_adv;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_REST: begin
                if (r_cnt == CNT_W'(REST_CYCLES - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                w_cnt_nxt = '0;
                if (!w_tank_empty) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_grant_nxt = 3'b000;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register
    always_comb begin
        w_pump_nxt  = (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_WATER);
        w_valve_nxt = (w_state_nxt == ST_WATER) ? w_grant_nxt : 3'b000;
        w_busy_nxt  = (w_state_nxt != ST_IDLE);
        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_grant     <= 3'b000;
            r_ptr       <= 3'b001;
            r_pump      <= 1'b0;
            r_sprinkler <= 1'b0;
            r_drip      <= 1'b0;
            r_specific  <= 1'b0;
            r_busy      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_grant     <= w_grant_nxt;
            r_ptr       <= w_ptr_nxt;
            r_pump      <= w_pump_nxt;
            r_sprinkler <= w_valve_nxt[0];
            r_drip      <= w_valve_nxt[1];
            r_specific  <= w_valve_nxt[2];
            r_busy      <= w_busy_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign pump_on         = r_pump;
    assign sprinkler_valve = r_sprinkler;
    assign drip_valve      = r_drip;
    assign specific_valve  = r_specific;
    assign busy            = r_busy;
    assign tank_fault      = r_fault;

`ifdef IRRIGATION_STATS_EN
    logic [15:0] r_water_cycles;

    // Saturating count of cycles with any valve open
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_water_cycles <= 16'h0000;
        end else if ((r_sprinkler || r_drip || r_specific) && (r_water_cycles != 16'hFFFF)) begin
            r_water_cycles <= r_water_cycles + 16'd1;
        end
    end

    assign water_cycles = r_water_cycles;
`endif

endmodule

// File: tb/tb_irrigation_controller.sv
// Directed bench for irrigation_controller: grant timing, round-robin order, soil abort, tank fault, async reset.
module tb_irrigation_controller;

    logic       clk;
    logic       reset_n;
    logic       sprinkler_req;
    logic       drip_req;
    logic       specific_req;
    logic       soil_umidity;
    logic [1:0] water_box;
    logic       pump_on;
    logic       sprinkler_valve;
    logic       drip_valve;
    logic       specific_valve;
    logic       busy;
    logic       tank_fault;
`ifdef IRRIGATION_STATS_EN
    logic [15:0] water_cycles;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [5:0] obs;
    assign obs = {pump_on, sprinkler_valve, drip_valve, specific_valve, busy, tank_fault};

    irrigation_controller dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .sprinkler_req   (sprinkler_req),
        .drip_req        (drip_req),
        .specific_req    (specific_req),
        .soil_umidity    (soil_umidity),
        .water_box       (water_box),
        .pump_on         (pump_on),
        .sprinkler_valve (sprinkler_valve),
        .drip_valve      (drip_valve),
        .specific_valve  (specific_valve),
        .busy            (busy),
        .tank_fault      (tank_fault)
`ifdef IRRIGATION_STATS_EN
        ,
        .water_cycles    (water_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] V_SPR  = 3'b100;
    localparam logic [2:0] V_DRIP = 3'b010;
    localparam logic [2:0] V_SPEC = 3'b001;

    // Expected {pump, spr, drip, spec, busy, fault} c cycles after the granting edge
    function automatic logic [5:0] profile(input int c, input int wlen, input logic [2:0] valve);
        if (c < 4)              return {1'b1, 3'b000, 1'b1, 1'b0};
        else if (c < 4 + wlen)  return {1'b1, valve, 1'b1, 1'b0};
        else if (c < 12 + wlen) return 6'b000010;
        else                    return 6'b000000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n       = 1'b0;
        sprinkler_req = 1'b0;
        drip_req      = 1'b0;
        specific_req  = 1'b0;
        soil_umidity  = 1'b0;
        water_box     = 2'b10;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        sprinkler_req = 1'b0;
        drip_req      = 1'b0;
        specific_req  = 1'b0;
        soil_umidity  = 1'b0;
        water_box     = 2'b10;
        repeat (2) tick();
        n_vec++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_held got %b want %b", obs, 6'b000000);
        end
        reset_n = 1'b1;
        tick();
        n_vec++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL reset_idle got %b want %b", obs, 6'b000000);
        end
    endtask

    task automatic test_single_grant();
        logic [5:0] exp;
        sprinkler_req = 1'b1;
        for (int c = 0; c < 29; c++) begin
            tick();
            exp = profile(c, 16, V_SPR);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL single_grant cyc %0d got %b want %b", c, obs, exp);
            end
        end
        tick();
        exp = 6'b100010;
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL regrant got %b want %b", obs, exp);
        end
    endtask

    task automatic test_drop_in_prime();
        logic [5:0] exp;
        sprinkler_req = 1'b0;
        for (int c = 1; c < 14; c++) begin
            tick();
            exp = profile(c, 1, V_SPR);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL drop_in_prime cyc %0d got %b want %b", c, obs, exp);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [5:0] exp;
        logic [2:0] order [4];
        order[0] = V_SPR;
        order[1] = V_DRIP;
        order[2] = V_SPEC;
        order[3] = V_SPR;
        apply_reset();
        sprinkler_req = 1'b1;
        drip_req      = 1'b1;
        specific_req  = 1'b1;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 29; c++) begin
                tick();
                exp = profile(c, 16, order[g]);
                n_vec++;
                if (obs !== exp) begin
                    n_err++;
                    $display("FAIL round_robin grant %0d cyc %0d got %b want %b", g, c, obs, exp);
                end
            end
        end
        sprinkler_req = 1'b0;
        drip_req      = 1'b0;
        specific_req  = 1'b0;
    endtask

    task automatic test_soil_abort();
        logic [5:0] exp;
        drip_req = 1'b1;
        for (int c = 0; c < 18; c++) begin
            tick();
            exp = profile(c, 5, V_DRIP);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL soil_abort cyc %0d got %b want %b", c, obs, exp);
            end
            if (c == 8) soil_umidity = 1'b1;
            if (c == 9) soil_umidity = 1'b0;
        end
        drip_req = 1'b0;
    endtask

    task automatic test_tank_fault();
        logic [5:0] exp;
        sprinkler_req = 1'b1;
        drip_req      = 1'b1;
        specific_req  = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            exp = profile(c, 16, V_SPEC);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL fault_pre cyc %0d got %b want %b", c, obs, exp);
            end
        end
        water_box = 2'b00;
        tick();
        n_vec++;
        if (obs !== 6'b000011) begin
            n_err++;
            $display("FAIL fault_entry got %b want %b", obs, 6'b000011);
        end
        water_box = 2'b10;
        tick();
        n_vec++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL fault_exit got %b want %b", obs, 6'b000000);
        end
        for (int c = 0; c < 29; c++) begin
            tick();
            exp = profile(c, 16, V_SPR);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL fault_next_grant cyc %0d got %b want %b", c, obs, exp);
            end
        end
        sprinkler_req = 1'b0;
        drip_req      = 1'b0;
        specific_req  = 1'b0;
        water_box     = 2'b00;
        tick();
        n_vec++;
        if (obs !== 6'b000011) begin
            n_err++;
            $display("FAIL idle_empty got %b want %b", obs, 6'b000011);
        end
        water_box = 2'b01;
        tick();
        n_vec++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL refill_01 got %b want %b", obs, 6'b000000);
        end
    endtask

    task automatic test_reset_mid_prime();
        logic [5:0] exp;
        sprinkler_req = 1'b1;
        drip_req      = 1'b1;
        specific_req  = 1'b1;
        repeat (2) tick();
        n_vec++;
        if (obs !== 6'b100010) begin
            n_err++;
            $display("FAIL mid_prime got %b want %b", obs, 6'b100010);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 6'b000000) begin
            n_err++;
            $display("FAIL async_reset got %b want %b", obs, 6'b000000);
        end
        #1;
        reset_n = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_after_reset got %b want %b", busy, 1'b0);
        end
        for (int c = 0; c < 29; c++) begin
            tick();
            exp = profile(c, 16, V_SPR);
            n_vec++;
            if (obs !== exp) begin
                n_err++;
                $display("FAIL post_reset_grant cyc %0d got %b want %b", c, obs, exp);
            end
        end
        sprinkler_req = 1'b0;
        drip_req      = 1'b0;
        specific_req  = 1'b0;
    endtask

`ifdef IRRIGATION_STATS_EN
    task automatic test_stats();
        apply_reset();
        sprinkler_req = 1'b1;
        repeat (58) tick();
        sprinkler_req = 1'b0;
        tick();
        n_vec++;
        if (water_cycles !== 16'd32) begin
            n_err++;
            $display("FAIL stats_count got %0d want %0d", water_cycles, 32);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_grant();
        test_drop_in_prime();
        test_round_robin();
        test_soil_abort();
        test_tank_fault();
        test_reset_mid_prime();
`ifdef IRRIGATION_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
